// File: rtl/dcache_dm_wt.sv
// dcache_dm_wt: direct-mapped, write-through, no-write-allocate data cache
// between the CPU MEM stage and data memory. Lines are refilled with a
// word-by-word handshaked burst. The pipeline is stalled during refills and
// during every write.
// Optional macro DCACHE_STATS_EN adds saturating hit_count/miss_count outputs.
module dcache_dm_wt #(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 16,
    parameter int INDEX_W  = 3,
    parameter int OFFSET_W = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cpu_re,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              stall,
    output logic              hit,
    output logic              miss,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
`ifdef DCACHE_STATS_EN
    ,
    output logic [15:0]       hit_count,
    output logic [15:0]       miss_count
`endif
);

    localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;
    localparam int LINES = 1 << INDEX_W;
    localparam int WORDS = 1 << OFFSET_W;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REFILL = 2'd1,
        ST_WRITE  = 2'd2
    } state_t;

    state_t              state_r, state_nx_s;
    logic [LINES-1:0]    valid_r;
    logic [TAG_W-1:0]    tag_r  [LINES];
    logic [DATA_W-1:0]   data_r [LINES*WORDS];
    logic [OFFSET_W-1:0] cnt_r;
    logic [ADDR_W-1:0]   addr_r;
    logic [DATA_W-1:0]   wdata_r;
    logic                miss_r;
    logic                wr_hit_r;
    logic                wr_done_r;
    logic                refill_done_r;

    logic [TAG_W-1:0]    cpu_tag_s;
    logic [INDEX_W-1:0]  cpu_idx_s;
    logic [OFFSET_W-1:0] cpu_off_s;
    logic [INDEX_W-1:0]  line_idx_s;
    logic                lookup_hit_s;
    logic                hit_s;
    logic                stall_s;
    logic                start_refill_s;
    logic                start_write_s;
    logic                refill_ack_s;
    logic                refill_last_s;
    logic                write_ack_s;

    assign cpu_tag_s    = cpu_addr[ADDR_W-1 -: TAG_W];
    assign cpu_idx_s    = cpu_addr[OFFSET_W +: INDEX_W];
    assign cpu_off_s    = cpu_addr[OFFSET_W-1:0];
    assign line_idx_s   = addr_r[OFFSET_W +: INDEX_W];
    assign lookup_hit_s = valid_r[cpu_idx_s] && (tag_r[cpu_idx_s] == cpu_tag_s);

    // Next-state decode, stall/hit generation and read data mux
    always_comb begin
        state_nx_s     = state_r;
        stall_s        = 1'b0;
        hit_s          = 1'b0;
        cpu_rdata      = '0;
        start_refill_s = 1'b0;
        start_write_s  = 1'b0;
        refill_ack_s   = 1'b0;
        refill_last_s  = 1'b0;
        write_ack_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                hit_s = (cpu_re || cpu_we) && lookup_hit_s;
                if (cpu_we) begin
                    // wr_done_r marks the cycle in which a finished write is
                    // still presented; it must release, not restart.
                    if (!wr_done_r) begin
                        stall_s       = 1'b1;
                        start_write_s = 1'b1;
                        state_nx_s    = ST_WRITE;
                    end else begin
                        stall_s = 1'b0;
                    end
                end else if (cpu_re) begin
                    if (lookup_hit_s) begin
                        cpu_rdata = data_r[{cpu_idx_s, cpu_off_s}];
                    end else begin
                        stall_s        = 1'b1;
                        start_refill_s = 1'b1;
                        state_nx_s     = ST_REFILL;
                    end
                end else begin
                    stall_s = 1'b0;
                end
            end
            ST_REFILL: begin
                stall_s      = 1'b1;
                refill_ack_s = mem_ack;
                if (mem_ack && (cnt_r == OFFSET_W'(WORDS - 1))) begin
                    refill_last_s = 1'b1;
                    state_nx_s    = ST_IDLE;
                end else begin
                    state_nx_s = ST_REFILL;
                end
            end
            ST_WRITE: begin
                stall_s = 1'b1;
                if (mem_ack) begin
                    write_ack_s = 1'b1;
                    state_nx_s  = ST_IDLE;
                end else begin
                    state_nx_s = ST_WRITE;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // Handshake outputs are pure functions of the state register
    always_comb begin
        mem_req   = (state_r != ST_IDLE);
        mem_we    = (state_r == ST_WRITE);
        mem_addr  = '0;
        mem_wdata = '0;
        case (state_r)
            ST_REFILL: mem_addr = {addr_r[ADDR_W-1:OFFSET_W], cnt_r};
            ST_WRITE: begin
                mem_addr  = addr_r;
                mem_wdata = wdata_r;
            end
            default: mem_addr = '0;
        endcase
    end

    // While reset is held, stall and hit are forced low whatever the CPU drives
    assign stall = reset & stall_s;
    assign hit   = reset & hit_s;
    assign miss  = miss_r;

    // FSM, tag/valid array, refill counter and captured request
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r       <= ST_IDLE;
            valid_r       <= '0;
            cnt_r         <= '0;
            addr_r        <= '0;
            wdata_r       <= '0;
            miss_r        <= 1'b0;
            wr_hit_r      <= 1'b0;
            wr_done_r     <= 1'b0;
            refill_done_r <= 1'b0;
            for (int i = 0; i < LINES; i++) begin
                tag_r[i] <= '0;
            end
        end else begin
            state_r       <= state_nx_s;
            miss_r        <= start_refill_s;
            wr_done_r     <= write_ack_s;
            refill_done_r <= refill_last_s;
            if (start_refill_s) begin
                // Line stays invalid until its last word has arrived
                addr_r             <= cpu_addr;
                cnt_r              <= '0;
                valid_r[cpu_idx_s] <= 1'b0;
            end
            if (start_write_s) begin
                addr_r   <= cpu_addr;
                wdata_r  <= cpu_wdata;
                wr_hit_r <= lookup_hit_s;
            end
            if (refill_ack_s) begin
                cnt_r <= cnt_r + 1'b1;
            end
            if (refill_last_s) begin
                tag_r[line_idx_s]   <= addr_r[ADDR_W-1 -: TAG_W];
                valid_r[line_idx_s] <= 1'b1;
            end
        end
    end

    // Data RAM: refill words and write-hit updates (contents are not reset)
    always_ff @(posedge clock) begin
        if (refill_ack_s) begin
            data_r[{line_idx_s, cnt_r}] <= mem_rdata;
        end else if (write_ack_s && wr_hit_r) begin
            data_r[{line_idx_s, addr_r[OFFSET_W-1:0]}] <= wdata_r;
        end
    end

`ifdef DCACHE_STATS_EN
    logic read_hit_evt_s;
    logic write_hit_evt_s;

    // The re-lookup right after a refill is the tail of a miss, not a hit
    assign read_hit_evt_s  = hit_s && cpu_re && !cpu_we && !refill_done_r;
    assign write_hit_evt_s = write_ack_s && wr_hit_r;

    // Saturating hit/miss statistics
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hit_count  <= 16'h0000;
            miss_count <= 16'h0000;
        end else begin
            if ((read_hit_evt_s || write_hit_evt_s) && (hit_count != 16'hFFFF)) begin
                hit_count <= hit_count + 16'h0001;
            end
            if (miss_r && (miss_count != 16'hFFFF)) begin
                miss_count <= miss_count + 16'h0001;
            end
        end
    end
`endif

endmodule
